// File: rtl/lab1_sweep_pkg.sv
// ----------------------------------------------------------------------------
// lab1_sweep_pkg
// Shared definitions for the Lab1 sel-sweep sequencer: FSM state encoding,
// record field widths/offsets and the record width REC_W.
//
// Build option: LAB1_SWEEP_TIMESTAMP_EN
//   defined   -> REC_W = 32, rec_data[31:16] carries a 16-bit cycle timestamp
//   undefined -> REC_W = 16, no timestamp field
// ----------------------------------------------------------------------------
package lab1_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        PUSH  = 3'd2,
        STALL = 3'd3,
        FIN   = 3'd4
    } state_e;

    // Operand / result widths of the Lab1_top instance being swept.
    localparam int X_W   = 3;
    localparam int Y_W   = 3;
    localparam int SEL_W = 2;
    localparam int OUT_W = 8;

    // Hold counter width; covers HOLD_CYCLES up to 255.
    localparam int CNT_W = 8;

    // Record layout: {dut_x, dut_y, dut_sel, sampled_out}, MSB = dut_x[2].
    localparam int OUT_LSB = 0;
    localparam int SEL_LSB = OUT_LSB + OUT_W;   // 8
    localparam int Y_LSB   = SEL_LSB + SEL_W;   // 10
    localparam int X_LSB   = Y_LSB + Y_W;       // 13
    localparam int BASE_W  = X_LSB + X_W;       // 16

`ifdef LAB1_SWEEP_TIMESTAMP_EN
    localparam int TS_W   = 16;
    localparam int TS_LSB = BASE_W;             // 16
    localparam int REC_W  = BASE_W + TS_W;      // 32
`else
    localparam int REC_W  = BASE_W;             // 16
`endif

    // Packs the timestamp-independent part of a record.
    function automatic logic [BASE_W-1:0] pack_base(
        input logic [X_W-1:0]   x,
        input logic [Y_W-1:0]   y,
        input logic [SEL_W-1:0] sel,
        input logic [OUT_W-1:0] res
    );
        return {x, y, sel, res};
    endfunction

endpackage

// File: rtl/lab1_sweep_seq_if.sv
// ----------------------------------------------------------------------------
// lab1_sweep_seq_if
// Record stream between the sweep sequencer (master) and a record consumer
// (slave).
//
// Handshake: rec_valid/rec_data are driven by the master; rec_ready by the
// slave. A record transfers on every clock edge where rec_valid && rec_ready.
// rec_valid never depends on rec_ready, and rec_data is stable while
// rec_valid is high and no transfer has occurred.
//
// Signals:
//   rec_valid  head record available
//   rec_ready  consumer accepts the head record
//   rec_data   head record, REC_W bits
// ----------------------------------------------------------------------------
interface lab1_sweep_seq_if;
    import lab1_sweep_pkg::*;

    logic             rec_valid;
    logic             rec_ready;
    logic [REC_W-1:0] rec_data;

    modport master (
        output rec_valid,
        output rec_data,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_data,
        output rec_ready
    );

endinterface

// File: rtl/lab1_rec_fifo.sv
// ----------------------------------------------------------------------------
// lab1_rec_fifo
// First-word-fall-through record buffer. The oldest entry is always presented
// on rd_data_o while rd_valid_o is high; rd_data_o reads as zero when empty.
// A write is accepted while full if a read happens in the same cycle.
//
// Parameters: WIDTH (entry width), DEPTH (power of two, >= 2)
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   wr_valid_i   write request
//   wr_ready_o   write will be accepted this cycle
//   wr_data_i    write data
//   rd_valid_o   buffer non-empty
//   rd_ready_i   consumer takes the head entry
//   rd_data_o    head entry
//   count_o      current occupancy
// ----------------------------------------------------------------------------
module lab1_rec_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    logic full;
    logic pop;
    logic push;

    assign full       = (count_q == CNT_FULL);
    assign rd_valid_o = (count_q != '0);
    assign pop        = rd_valid_o && rd_ready_i;
    // A simultaneous pop frees the slot the write needs, even when full.
    assign wr_ready_o = !full || pop;
    assign push       = wr_valid_i && wr_ready_o;
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible while non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/lab1_sweep_seq.sv
// ----------------------------------------------------------------------------
// lab1_sweep_seq
// Sweeps the sel input of a Lab1_top instance through 0..3 for one latched
// (X, Y) pair. Each sel code is held HOLD_CYCLES cycles, then the instance
// output is sampled and a record {x, y, sel, out} is buffered in a FWFT FIFO
// that the consumer drains independently of the sweep.
//
// Build option: LAB1_SWEEP_TIMESTAMP_EN -- adds a free-running 16-bit cycle
// counter whose value at the sample cycle fills rec_data[31:16].
//
// Parameters: HOLD_CYCLES (1..255), FIFO_DEPTH (power of two, >= 2)
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            request one sweep (dropped while busy)
//   x_in, y_in       operands, latched when start is accepted
//   dut_x, dut_y     operands driven to the Lab1_top instance
//   dut_sel          sel driven to the Lab1_top instance
//   dut_out          result from the Lab1_top instance
//   rec              record stream (master side)
//   busy             sweep in progress
//   done             one-cycle pulse at the end of a sweep
//   dbg_state        current FSM state
//   dbg_count        current FIFO occupancy
// ----------------------------------------------------------------------------
module lab1_sweep_seq
    import lab1_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [X_W-1:0]                x_in,
    input  logic [Y_W-1:0]                y_in,
    output logic [X_W-1:0]                dut_x,
    output logic [Y_W-1:0]                dut_y,
    output logic [SEL_W-1:0]              dut_sel,
    input  logic [OUT_W-1:0]              dut_out,
    lab1_sweep_seq_if.master              rec,
    output logic                          busy,
    output logic                          done,
    output state_e                        dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]   dbg_count
);

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = '1;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [SEL_W-1:0]   sel_q;
    logic [OUT_W-1:0]   smp_q;
    logic               done_q;

    logic               sample;
    logic               wr_valid;
    logic               wr_ready;
    logic [REC_W-1:0]   wr_data;

    // The sample cycle is the last of the HOLD_CYCLES DRIVE cycles.
    assign sample   = (state_q == DRIVE) && (cnt_q == HOLD_LAST);
    assign wr_valid = (state_q == PUSH) || (state_q == STALL);

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sel_q   <= '0;
            smp_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q     <= x_in;
                        y_q     <= y_in;
                        sel_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (sample) begin
                        smp_q   <= dut_out;
                        state_q <= PUSH;
                    end
                end
                PUSH, STALL: begin
                    // The record stays in smp_q/sel_q until the FIFO takes
                    // it, so a stall neither drops nor repeats it.
                    if (wr_ready) begin
                        if (sel_q == SEL_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            sel_q   <= sel_q + 1'b1;
                            cnt_q   <= '0;
                            state_q <= DRIVE;
                        end
                    end else begin
                        state_q <= STALL;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Record assembly
    // ------------------------------------------------------------------
`ifdef LAB1_SWEEP_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] ts_smp_q;

    // Free-running; wraps 0xFFFF -> 0. Captured alongside dut_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q     <= '0;
            ts_smp_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
            if (sample) begin
                ts_smp_q <= ts_q;
            end
        end
    end

    assign wr_data = {ts_smp_q, pack_base(x_q, y_q, sel_q, smp_q)};
`else
    assign wr_data = pack_base(x_q, y_q, sel_q, smp_q);
`endif

    // ------------------------------------------------------------------
    // Record buffer
    // ------------------------------------------------------------------
    lab1_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_valid_i (wr_valid),
        .wr_ready_o (wr_ready),
        .wr_data_i  (wr_data),
        .rd_valid_o (rec.rec_valid),
        .rd_ready_i (rec.rec_ready),
        .rd_data_o  (rec.rec_data),
        .count_o    (dbg_count)
    );

    assign dut_x     = x_q;
    assign dut_y     = y_q;
    assign dut_sel   = sel_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lab1_sweep_seq.sv
// ----------------------------------------------------------------------------
// tb_lab1_sweep_seq
// Directed bench for lab1_sweep_seq with a stub Lab1_top (out = {X,Y}+sel),
// HOLD_CYCLES=10 and FIFO_DEPTH=2.
// ----------------------------------------------------------------------------
module tb_lab1_sweep_seq;
    import lab1_sweep_pkg::*;

    localparam int HC = 10;
    localparam int FD = 2;
    localparam int CW = $clog2(FD) + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2:0]     x_in;
    logic [2:0]     y_in;
    logic [2:0]     dut_x;
    logic [2:0]     dut_y;
    logic [1:0]     dut_sel;
    logic [7:0]     dut_out;
    logic           busy;
    logic           done;
    state_e         dbg_state;
    logic [CW-1:0]  dbg_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0]      exp_q[$];
    logic [REC_W-1:0] got_q[$];
    int               done_seen;

    lab1_sweep_seq_if rec ();

    always #5 clk = ~clk;

    // Stub Lab1_top: out = {X,Y} + sel.
    assign dut_out = {2'b00, dut_x, dut_y} + {6'b0, dut_sel};

    lab1_sweep_seq #(
        .HOLD_CYCLES (HC),
        .FIFO_DEPTH  (FD)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .dut_x     (dut_x),
        .dut_y     (dut_y),
        .dut_sel   (dut_sel),
        .dut_out   (dut_out),
        .rec       (rec),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    // Compares collected records with exp_q, then the done pulse count.
    task automatic check_records(input string name);
        logic [REC_W-1:0] r;
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d records, expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size()) begin
                n_fail++;
                $display("FAIL %s_rec%0d: missing, expected %h", name, i, exp_q[i]);
            end else begin
                r = got_q[i];
                if (r[15:0] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL %s_rec%0d: got %h expected %h", name, i, r[15:0], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        x_in = 3'd0;
        y_in = 3'd0;
        rec.rec_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (rec.rec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rec.rec_valid); end
        n_checks++;
        if (rec.rec_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rec.rec_data); end
        n_checks++;
        if ({dut_x, dut_y, dut_sel} !== 8'h00) begin
            n_fail++; $display("FAIL reset_dut_bus: got x=%0d y=%0d sel=%0d expected 0/0/0", dut_x, dut_y, dut_sel);
        end
        n_checks++;
        if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    endtask

    task automatic test_nominal();
        int cycles;
        int first_lat;
        first_lat = -1;
        cycles = 0;
        done_seen = 0;
        got_q.delete();
        exp_q = '{16'hAC2B, 16'hAD2C, 16'hAE2D, 16'hAF2E};
        x_in = 3'd5;
        y_in = 3'd3;
        rec.rec_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (done) done_seen++;
            if (rec.rec_valid) begin
                if (first_lat < 0) first_lat = cycles;
                got_q.push_back(rec.rec_data);
            end
        end
        n_checks++;
        if (first_lat !== HC + 2) begin
            n_fail++; $display("FAIL nominal_latency: got %0d cycles expected %0d", first_lat, HC + 2);
        end
        check_records("nominal");
        n_checks++;
        if (done_seen !== 1) begin n_fail++; $display("FAIL nominal_done: got %0d pulses expected 1", done_seen); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL nominal_idle_busy: got %b expected 0", busy); end
        n_checks++;
        if ({dut_x, dut_y, dut_sel} !== {3'd5, 3'd3, 2'd3}) begin
            n_fail++; $display("FAIL nominal_hold: got x=%0d y=%0d sel=%0d expected 5/3/3", dut_x, dut_y, dut_sel);
        end
`ifdef LAB1_SWEEP_TIMESTAMP_EN
        for (int i = 1; i < got_q.size(); i++) begin
            logic [15:0] ts_a;
            logic [15:0] ts_b;
            logic [REC_W-1:0] ra;
            logic [REC_W-1:0] rb;
            ra = got_q[i-1];
            rb = got_q[i];
            ts_a = ra[31:16];
            ts_b = rb[31:16];
            n_checks++;
            if (16'(ts_b - ts_a) !== 16'd11) begin
                n_fail++; $display("FAIL nominal_ts%0d: got delta %0d expected 11", i, 16'(ts_b - ts_a));
            end
        end
`endif
    endtask

    task automatic test_start_busy();
        logic busy_at_restart;
        busy_at_restart = 1'b0;
        done_seen = 0;
        got_q.delete();
        exp_q = '{16'hAC2B, 16'hAD2C, 16'hAE2D, 16'hAF2E};
        x_in = 3'd5;
        y_in = 3'd3;
        rec.rec_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) done_seen++;
            if (rec.rec_valid) got_q.push_back(rec.rec_data);
            if (i == 20) begin
                busy_at_restart = busy;
                x_in = 3'd7;
                y_in = 3'd2;
                start = 1'b1;
            end
        end
        n_checks++;
        if (busy_at_restart !== 1'b1) begin n_fail++; $display("FAIL busy_midsweep: got %b expected 1", busy_at_restart); end
        check_records("start_busy");
        n_checks++;
        if (done_seen !== 1) begin n_fail++; $display("FAIL start_busy_done: got %0d pulses expected 1", done_seen); end
        n_checks++;
        if ({dut_x, dut_y} !== {3'd5, 3'd3}) begin
            n_fail++; $display("FAIL start_busy_operands: got x=%0d y=%0d expected 5/3", dut_x, dut_y);
        end
    endtask

    task automatic test_backpressure();
        rec.rec_ready = 1'b0;
        x_in = 3'd6;
        y_in = 3'd7;
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (dbg_state == STALL) break;
        end
        n_checks++;
        if (dbg_state !== STALL) begin n_fail++; $display("FAIL bp_stall: got state %0d expected %0d", dbg_state, STALL); end
        n_checks++;
        if (dbg_count !== CW'(FD)) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", dbg_count, FD); end
        n_checks++;
        if (rec.rec_data[15:0] !== 16'hDC37) begin
            n_fail++; $display("FAIL bp_head: got %h expected dc37", rec.rec_data[15:0]);
        end
        n_checks++;
        if (dut_sel !== 2'd2) begin n_fail++; $display("FAIL bp_sel: got %0d expected 2", dut_sel); end
    endtask

    // Continues the stalled sweep left by test_backpressure.
    task automatic test_push_pop();
        rec.rec_ready = 1'b1;
        @(negedge clk);
        rec.rec_ready = 1'b0;
        n_checks++;
        if (dbg_count !== CW'(FD)) begin n_fail++; $display("FAIL pp_count: got %0d expected %0d", dbg_count, FD); end
        n_checks++;
        if (rec.rec_data[15:0] !== 16'hDD38) begin
            n_fail++; $display("FAIL pp_head: got %h expected dd38", rec.rec_data[15:0]);
        end
        n_checks++;
        if (dbg_state !== DRIVE) begin n_fail++; $display("FAIL pp_state: got %0d expected %0d", dbg_state, DRIVE); end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dbg_state == STALL) break;
        end
        n_checks++;
        if (dbg_state !== STALL) begin n_fail++; $display("FAIL pp_stall2: got state %0d expected %0d", dbg_state, STALL); end
        got_q.delete();
        done_seen = 0;
        exp_q = '{16'hDD38, 16'hDE39, 16'hDF3A};
        rec.rec_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (rec.rec_valid) got_q.push_back(rec.rec_data);
            @(negedge clk);
            if (done) done_seen++;
        end
        check_records("drain");
        n_checks++;
        if (done_seen !== 1) begin n_fail++; $display("FAIL drain_done: got %0d pulses expected 1", done_seen); end
    endtask

    task automatic test_reset_mid();
        int bad_valid;
        int bad_busy;
        bad_valid = 0;
        bad_busy = 0;
        done_seen = 0;
        rec.rec_ready = 1'b0;
        x_in = 3'd3;
        y_in = 3'd4;
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (dut_sel == 2'd2) break;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_sel !== 2'd2 || dbg_count !== CW'(FD)) begin
            n_fail++; $display("FAIL rst_pre: got sel=%0d count=%0d expected 2/%0d", dut_sel, dbg_count, FD);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (rec.rec_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_flags: got valid=%b busy=%b expected 0/0", rec.rec_valid, busy);
        end
        n_checks++;
        if ({dut_x, dut_y, dut_sel} !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid_bus: got x=%0d y=%0d sel=%0d expected 0/0/0", dut_x, dut_y, dut_sel);
        end
        n_checks++;
        if (rec.rec_data !== '0 || dbg_count !== '0) begin
            n_fail++; $display("FAIL rst_mid_fifo: got data=%h count=%0d expected 0/0", rec.rec_data, dbg_count);
        end
        @(negedge clk);
        rst = 1'b0;
        rec.rec_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (rec.rec_valid) bad_valid++;
            if (busy) bad_busy++;
        end
        n_checks++;
        if (done_seen !== 0 || bad_valid !== 0 || bad_busy !== 0) begin
            n_fail++; $display("FAIL rst_after: got done=%0d valid=%0d busy=%0d cycles expected 0/0/0", done_seen, bad_valid, bad_busy);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_start_busy();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_nominal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
